// File: rtl/sccb_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_seq_pkg
// Description : Shared types and constants for the SCCB configuration
//               sequencer: FSM state encoding and ROM word tags.
// Revision    : 1.0 - initial release
// ============================================================================
package sccb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_DELAY    = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } seq_state_t;

  localparam logic [15:0] SEQ_END_WORD  = 16'hFFFF;
  localparam logic [7:0]  SEQ_DELAY_TAG = 8'hFF;

  // A delay entry carries the tag in the upper byte and is not the end marker.
  function automatic logic is_delay_word(input logic [15:0] word);
    return (word[15:8] == SEQ_DELAY_TAG) && (word != SEQ_END_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_delay_timer
// Description : Loadable down-counter used for inter-entry delays. Counts down
//               by one per enabled cycle and rests at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_delay_timer #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_config_sequencer
// Description : Walks a settings ROM table and issues register writes to an
//               SCCB master, honouring delay entries and an end marker.
//               Optional macro SCCB_RETRY_EN: retry NACKed writes up to
//               MAX_RETRY times before flagging an error.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_config_sequencer
  import sccb_seq_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter int NUM_TABLES = 2,
  parameter int DELAY_UNIT = 27000,
  parameter int MAX_RETRY  = 3,
  localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [SEL_W-1:0] table_sel_i,
  output logic [SEL_W-1:0] rom_sel_o,
  output logic [IDX_W-1:0] rom_addr_o,
  input  logic [15:0]      rom_data_i,
  output logic             wr_valid_o,
  input  logic             wr_ready_i,
  output logic [7:0]       wr_reg_o,
  output logic [7:0]       wr_data_o,
  input  logic             wr_done_i,
  input  logic             wr_nack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_idx_o
);

  // Counter must hold 255 * DELAY_UNIT.
  localparam int               CNT_W    = $clog2(255 * DELAY_UNIT + 1);
  localparam logic [CNT_W-1:0] UNIT_C   = CNT_W'(DELAY_UNIT);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  seq_state_t       state, next_state;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel;
  logic [15:0]      word;
  logic             accept_start, latch_word, load_payload;
  logic             timer_load, timer_zero, entry_done, set_error;
  logic [CNT_W-1:0] delay_load;

`ifdef SCCB_RETRY_EN
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_inc;
`endif

  // The DELAY state lasts exactly nn*DELAY_UNIT cycles, so load one less.
  assign delay_load = (CNT_W'(word[7:0]) * UNIT_C) - CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    latch_word   = 1'b0;
    load_payload = 1'b0;
    timer_load   = 1'b0;
    entry_done   = 1'b0;
    set_error    = 1'b0;
`ifdef SCCB_RETRY_EN
    retry_inc    = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          accept_start = 1'b1;
          next_state   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        latch_word = 1'b1;
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (word == SEQ_END_WORD) begin
          next_state = ST_DONE;
        end else if (is_delay_word(word)) begin
          if (word[7:0] == 8'd0) begin
            entry_done = 1'b1;
          end else begin
            timer_load = 1'b1;
            next_state = ST_DELAY;
          end
        end else begin
          load_payload = 1'b1;
          next_state   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_ready_i) next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wr_done_i) begin
          if (!wr_nack_i) begin
            entry_done = 1'b1;
          end else begin
`ifdef SCCB_RETRY_EN
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              retry_inc  = 1'b1;
              next_state = ST_ISSUE;
            end else begin
              set_error  = 1'b1;
              next_state = ST_ERROR;
            end
`else
            set_error  = 1'b1;
            next_state = ST_ERROR;
`endif
          end
        end
      end
      ST_DELAY: begin
        if (timer_zero) entry_done = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
    // Finishing the last addressable entry without an end marker is an error;
    // the index never wraps.
    if (entry_done) begin
      if (idx == IDX_LAST) begin
        set_error  = 1'b1;
        next_state = ST_ERROR;
      end else begin
        next_state = ST_FETCH;
      end
    end
  end

  // Entry index, table latch, fetched word, write payload and error index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      sel       <= '0;
      word      <= '0;
      wr_reg_o  <= '0;
      wr_data_o <= '0;
      err_idx_o <= '0;
    end else begin
      if (accept_start) begin
        idx       <= '0;
        sel       <= table_sel_i;
        err_idx_o <= '0;
      end
      if (latch_word) word <= rom_data_i;
      if (load_payload) begin
        wr_reg_o  <= word[15:8];
        wr_data_o <= word[7:0];
      end
      if (entry_done && (idx != IDX_LAST)) idx <= idx + 1'b1;
      if (set_error) err_idx_o <= idx;
    end
  end

`ifdef SCCB_RETRY_EN
  // Retries are counted per entry; a fresh write clears the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          retry_cnt <= '0;
    else if (load_payload) retry_cnt <= '0;
    else if (retry_inc)    retry_cnt <= retry_cnt + 1'b1;
  end
`endif

  seq_delay_timer #(
    .CNT_W(CNT_W)
  ) u_delay_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .load_val(delay_load),
    .en      (state == ST_DELAY),
    .zero    (timer_zero)
  );

  assign rom_sel_o  = sel;
  assign rom_addr_o = idx;
  assign wr_valid_o = (state == ST_ISSUE);
  assign done_o     = (state == ST_DONE);
  assign error_o    = (state == ST_ERROR);
  assign busy_o     = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_config_sequencer
// Description : Directed self-checking bench for sccb_config_sequencer with a
//               behavioural settings ROM and SCCB master responder.
//               Honours SCCB_RETRY_EN for the NACK expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_config_sequencer;

  localparam int IDX_W = 4;
  localparam int DU    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_i = 1'b0;
  logic        table_sel_i = 1'b0;
  logic        wr_ready_i = 1'b1;
  logic        wr_done_i = 1'b0;
  logic        wr_nack_i = 1'b0;
  logic        rom_sel_o;
  logic [3:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        wr_valid_o, busy_o, done_o, error_o;
  logic [7:0]  wr_reg_o, wr_data_o;
  logic [3:0]  err_idx_o;

  logic [15:0] rom [0:1][0:15];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int nack_entry = -1;
  bit pend_done = 1'b0;
  bit pend_nack = 1'b0;
  bit sel_watch = 1'b0;
  int sel_bad_cnt = 0;
  logic [7:0] x_reg[$];
  logic [7:0] x_data[$];
  int         x_cyc[$];
  int         x_idx[$];

  sccb_config_sequencer #(
    .IDX_W(IDX_W), .NUM_TABLES(2), .DELAY_UNIT(DU), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .table_sel_i(table_sel_i),
    .rom_sel_o(rom_sel_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_reg_o(wr_reg_o),
    .wr_data_o(wr_data_o), .wr_done_i(wr_done_i), .wr_nack_i(wr_nack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o)
  );

  always #5 clk = ~clk;

  assign rom_data_i = rom[rom_sel_o][rom_addr_o];

  always @(posedge clk) cyc <= cyc + 1;

  // SCCB master model: log each transfer, answer with a done pulse one cycle later.
  always @(negedge clk) begin
    wr_done_i = 1'b0;
    wr_nack_i = 1'b0;
    if (pend_done) begin
      wr_done_i = 1'b1;
      wr_nack_i = pend_nack;
      pend_done = 1'b0;
    end
    if (wr_valid_o && wr_ready_i) begin
      x_reg.push_back(wr_reg_o);
      x_data.push_back(wr_data_o);
      x_cyc.push_back(cyc);
      x_idx.push_back(int'(rom_addr_o));
      pend_done = 1'b1;
      pend_nack = (int'(rom_addr_o) == nack_entry);
    end
  end

  // Table select must stay at the latched value for the whole run.
  always @(negedge clk) begin
    if (sel_watch && busy_o && (rom_sel_o !== 1'b1)) sel_bad_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++) rom[t][i] = 16'hFFFF;
  endtask

  task automatic do_start(input logic sel);
    tick();
    table_sel_i = sel;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int base, gap, cnt2, n, exp_issues;

    fill_rom();
    #3 reset_n = 1'b0;
    #1;
    check("rst_outputs", {wr_valid_o, busy_o, done_o, error_o, rom_addr_o, err_idx_o,
                          wr_reg_o, wr_data_o}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_idle", {busy_o, done_o, error_o, wr_valid_o}, 4'b0000);

    // Two writes separated by a 240-unit delay.
    rom[0][0] = 16'h1280; rom[0][1] = 16'hFFF0; rom[0][2] = 16'h1204; rom[0][3] = 16'hFFFF;
    base = x_reg.size();
    do_start(1'b0);
    check("t1_busy", {busy_o, done_o}, 2'b10);
    wait_idle(2000);
    check("t1_count", x_reg.size() - base, 2);
    if (x_reg.size() - base == 2) begin
      check("t1_w0", {x_reg[base], x_data[base]}, 16'h1280);
      check("t1_w1", {x_reg[base+1], x_data[base+1]}, 16'h1204);
      gap = x_cyc[base+1] - x_cyc[base];
      check("t1_gap_min", {31'd0, gap >= 240*DU}, 32'd1);
      check("t1_gap_max", {31'd0, gap <= 240*DU + 10}, 32'd1);
    end
    check("t1_status", {done_o, busy_o, error_o}, 3'b100);

    // Back-pressure: ready low for 10 cycles.
    fill_rom();
    rom[0][0] = 16'h3456;
    wr_ready_i = 1'b0;
    base = x_reg.size();
    do_start(1'b0);
    check("t2_done_clr", {31'd0, done_o}, 32'd0);
    n = 0;
    while (!wr_valid_o && n < 20) begin tick(); n++; end
    check("t2_valid_seen", {31'd0, wr_valid_o}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(wr_valid_o && wr_reg_o == 8'h34 && wr_data_o == 8'h56)) n++;
      tick();
    end
    check("t2_stable", n, 0);
    check("t2_no_xfer", x_reg.size() - base, 0);
    wr_ready_i = 1'b1;
    wait_idle(50);
    check("t2_one_xfer", x_reg.size() - base, 1);
    check("t2_done", {done_o, error_o}, 2'b10);

    // NACK on entry 2.
    fill_rom();
    rom[0][0] = 16'h1001; rom[0][1] = 16'h1102; rom[0][2] = 16'h1203; rom[0][3] = 16'h1304;
    nack_entry = 2;
`ifdef SCCB_RETRY_EN
    exp_issues = 4;
`else
    exp_issues = 1;
`endif
    base = x_reg.size();
    do_start(1'b0);
    wait_idle(200);
    nack_entry = -1;
    cnt2 = 0;
    for (int i = base; i < x_reg.size(); i++) if (x_idx[i] == 2) cnt2++;
    check("t3_issues", cnt2, exp_issues);
    check("t3_total", x_reg.size() - base, 2 + exp_issues);
    check("t3_status", {done_o, error_o}, 2'b01);
    check("t3_err_idx", {28'd0, err_idx_o}, 32'd2);

    // Full table without end marker: no wrap past the last index.
    for (int i = 0; i < 16; i++) rom[0][i] = {8'h20 + 8'(i), 8'(i)};
    base = x_reg.size();
    do_start(1'b0);
    check("t4_err_clr", {31'd0, error_o}, 32'd0);
    wait_idle(400);
    check("t4_count", x_reg.size() - base, 16);
    check("t4_last", {x_reg[x_reg.size()-1], x_data[x_data.size()-1]}, 16'h2F0F);
    check("t4_status", {done_o, error_o}, 2'b01);
    check("t4_err_idx", {28'd0, err_idx_o}, 32'd15);
    for (int i = 0; i < 10; i++) tick();
    check("t4_no_wrap", x_reg.size() - base, 16);

    // Reset pulse during a delay.
    fill_rom();
    rom[0][0] = 16'h1280; rom[0][1] = 16'hFF05; rom[0][2] = 16'h1204;
    base = x_reg.size();
    do_start(1'b0);
    n = 0;
    while (x_reg.size() == base && n < 30) begin tick(); n++; end
    for (int i = 0; i < 8; i++) tick();
    check("t5_in_delay", {busy_o, wr_valid_o}, 2'b10);
    reset_n = 1'b0;
    #1;
    check("t5_rst_outputs", {wr_valid_o, busy_o, done_o, error_o, rom_addr_o, err_idx_o,
                             wr_reg_o, wr_data_o}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("t5_no_resume", {x_reg.size() - base, 31'd0, busy_o}, {32'd1, 32'd0});
    base = x_reg.size();
    do_start(1'b0);
    wait_idle(200);
    check("t5_replay_count", x_reg.size() - base, 2);
    if (x_reg.size() - base == 2)
      check("t5_replay_first", {x_reg[base], x_data[base]}, 16'h1280);
    check("t5_done", {done_o, error_o}, 2'b10);

    // Table select latched on start.
    fill_rom();
    rom[0][0] = 16'h7701;
    rom[1][0] = 16'h5501; rom[1][1] = 16'h5602;
    base = x_reg.size();
    n = sel_bad_cnt;
    sel_watch = 1'b1;
    do_start(1'b1);
    tick();
    table_sel_i = 1'b0;
    wait_idle(100);
    sel_watch = 1'b0;
    check("t6_sel_stable", sel_bad_cnt - n, 0);
    check("t6_sel_after", {31'd0, rom_sel_o}, 32'd1);
    check("t6_count", x_reg.size() - base, 2);
    if (x_reg.size() - base == 2) begin
      check("t6_w0", {x_reg[base], x_data[base]}, 16'h5501);
      check("t6_w1", {x_reg[base+1], x_data[base+1]}, 16'h5602);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
